dmi_sba_preloader: RTL
======================

Name: dmi_sba_preloader

Overview:
- Synthesizable preload engine that sits directly upstream of the debug module's DMI port (`dm_ot` / `dm_top`).
- Consumes a stream of (address, 32-bit word) pairs from an ELF-loader or boot-ROM streamer.
- Converts the stream into DMI register writes that drive the System Bus Access (SBA) path into Ibex/safety SRAM, polling SBCS.sbbusy between accesses.
- Provides a hardware replacement for JTAG-driven preload, so the same SRAM image can be loaded without a TAP.

Parameters:
- DmiAddrW, 7, DMI address width.
- MaxPolls, 64, SBCS polls allowed per access before a timeout error.
- CntW, 16, width of the statistics counters (used only under the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  one-cycle pulse that begins a session; ignored unless in IDLE, DONE or ERROR
- in_valid_i  in  1  word stream valid
- in_ready_o  out  1  word stream ready
- in_addr_i  in  32  byte address of the word; bits [1:0] must be 0
- in_data_i  in  32  word data
- in_last_i  in  1  marks the final word of the session
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DMI request ready
- dmi_req_addr_o  out  DmiAddrW  DMI register address
- dmi_req_op_o  out  2  DMI operation: 1 = read, 2 = write
- dmi_req_data_o  out  32  DMI write data
- dmi_resp_valid_i  in  1  DMI response valid
- dmi_resp_ready_o  out  1  DMI response ready
- dmi_resp_data_i  in  32  DMI response data
- dmi_resp_resp_i  in  2  DMI response status; 0 = OK
- busy_o  out  1  session in progress
- done_o  out  1  level; session completed successfully
- error_o  out  1  level; session aborted with an error
- err_code_o  out  3  1 = DMI response error, 2 = poll timeout, 3 = sberror set, 4 = misaligned address

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Tracked next-address register `exp_addr` = 0; `addr_valid` = 0.
- DMI register map:
  - DMControl = 0x10
  - SBCS = 0x38
  - SBAddress0 = 0x39
  - SBData0 = 0x3C
- Transaction rule:
  - At most one DMI transaction outstanding.
  - A request is held stable until the valid&ready handshake completes.
  - `dmi_resp_ready_o` is 1 only in the response-wait states.
  - Every request, read or write, waits for its response.
  - A response with `dmi_resp_resp_i != 0` goes to ERROR with code 1.
- FSM states and transitions:
  - IDLE: on `start_i`, go to INIT_CTRL.
  - INIT_CTRL: write DMControl = 0x0000_0001. On response, go to INIT_SBCS.
  - INIT_SBCS: write SBCS = 0x0005_0000 (sbaccess = 2, sbautoincrement = 1). On response, go to WAIT_WORD.
  - WAIT_WORD:
    - `in_ready_o` = 1; the word is captured on handshake.
    - If `in_addr_i[1:0] != 0`, go to ERROR with code 4.
    - If `!addr_valid` or `in_addr_i != exp_addr`, go to WR_ADDR.
    - Otherwise go to WR_DATA.
  - WR_ADDR: write SBAddress0 = captured address; then POLL; then WR_DATA.
  - WR_DATA:
    - Write SBData0 = captured data.
    - Set `exp_addr` = address + 4 (wraps modulo 2^32) and `addr_valid` = 1.
    - Then POLL; then FINI if the captured `last` was 1, else WAIT_WORD.
  - POLL:
    - Read SBCS.
    - If bits [14:12] (sberror) != 0, go to ERROR with code 3.
    - If bit 21 (sbbusy) = 1, re-read; after MaxPolls busy reads, go to ERROR with code 2.
    - If bit 21 = 0, continue to the next state.
    - The poll counter clears on entry to POLL.
  - FINI: write SBCS = 0x0004_0000 (autoincrement off). Then DONE.
  - DONE: `done_o` = 1. `start_i` restarts a session; `addr_valid` is cleared.
  - ERROR: `error_o` = 1 and `err_code_o` holds the code. `start_i` restarts; `done_o`, `error_o` and `err_code_o` clear on restart.
- `busy_o` = 1 in every state except IDLE, DONE and ERROR.
- Boundary conditions:
  - `start_i` while busy is ignored.
  - `in_valid_i` outside WAIT_WORD is not accepted (`in_ready_o` = 0).
  - Address wrap: 0xFFFF_FFFC followed by 0x0000_0000 counts as contiguous.
  - Reset asserted mid-transaction: all outputs drop to reset values immediately (asynchronous); no DMI handshake is completed.
  - A response arriving in the same cycle the request handshakes is legal only for a later cycle; the response is sampled only in the response-wait state.

Optional Feature:
- Macro: DMI_SBA_PRELOADER_STATS_EN.
- When defined:
  - Adds output ports `words_o` [CntW-1:0] (SBData0 writes completed) and `polls_o` [CntW-1:0] (total SBCS reads).
  - Both counters saturate at all-ones and clear on `start_i`.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Contiguous section: start; words at 0x1000, 0x1004, 0x1008 (last); DMI always ready, sbbusy = 0 → DMI writes in order DMControl=1, SBCS=0x50000, SBAddress0=0x1000, SBData0 ×3 each followed by an SBCS read, SBCS=0x40000; `done_o` = 1; exactly one SBAddress0 write.
- Discontiguous: words 0x1000, 0x2000 (last) → two SBAddress0 writes (0x1000, 0x2000); `done_o` = 1.
- Busy polling: sbbusy = 1 for 3 reads, then 0 → 4 SBCS reads after that access, then the flow continues. With sbbusy stuck at 1 → exactly 64 reads, then `error_o` = 1, `err_code_o` = 2.
- Error paths:
  - sberror = 0b010 on a poll → ERROR, code 3.
  - DMI `resp` = 2 on the SBData0 write → ERROR, code 1.
  - Word address 0x1002 → ERROR, code 4, with no SBAddress0 write issued.
- Backpressure and reset: hold `dmi_req_ready_i` = 0 for 5 cycles → request address, op and data stable throughout. Assert `rst_ni` low mid-session → all outputs 0 asynchronously; a new start runs cleanly.
- Under DMI_SBA_PRELOADER_STATS_EN, the contiguous-section scenario ends with `words_o` = 3 and `polls_o` = 4.

Source files
------------

// File: rtl/dmi_sba_preloader_if.sv
// Word-stream and DMI request/response bundle for dmi_sba_preloader.
// master = preloader side, slave = stream source / debug module side.
interface dmi_sba_preloader_if #(
  parameter int unsigned DmiAddrW = 7
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         in_addr_i;
  logic [31:0]         in_data_i;
  logic                in_last_i;
  logic                dmi_req_valid_o;
  logic                dmi_req_ready_i;
  logic [DmiAddrW-1:0] dmi_req_addr_o;
  logic [1:0]          dmi_req_op_o;
  logic [31:0]         dmi_req_data_o;
  logic                dmi_resp_valid_i;
  logic                dmi_resp_ready_o;
  logic [31:0]         dmi_resp_data_i;
  logic [1:0]          dmi_resp_resp_i;

  modport master (
    input  in_valid_i, in_addr_i, in_data_i, in_last_i,
    output in_ready_o,
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    input  dmi_req_ready_i,
    input  dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    output dmi_resp_ready_o
  );

  modport slave (
    output in_valid_i, in_addr_i, in_data_i, in_last_i,
    input  in_ready_o,
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    output dmi_req_ready_i,
    output dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    input  dmi_resp_ready_o
  );
endinterface

// File: rtl/dmi_sba_preloader.sv
// Converts an (address, word) stream into DMI SBA writes with SBCS busy polling.
// Optional DMI_SBA_PRELOADER_STATS_EN adds saturating word/poll counters.
module dmi_sba_preloader #(
  parameter int unsigned DmiAddrW = 7,
  parameter int unsigned MaxPolls = 64
`ifdef DMI_SBA_PRELOADER_STATS_EN
  , parameter int unsigned CntW   = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  dmi_sba_preloader_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [2:0]           err_code_o
`ifdef DMI_SBA_PRELOADER_STATS_EN
  , output logic [CntW-1:0]    words_o
  , output logic [CntW-1:0]    polls_o
`endif
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_CTRL = 4'd1;
  localparam logic [3:0] S_INIT_SBCS = 4'd2;
  localparam logic [3:0] S_WAIT_WORD = 4'd3;
  localparam logic [3:0] S_WR_ADDR   = 4'd4;
  localparam logic [3:0] S_WR_DATA   = 4'd5;
  localparam logic [3:0] S_POLL      = 4'd6;
  localparam logic [3:0] S_FINI      = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERROR     = 4'd9;

  localparam logic [DmiAddrW-1:0] AddrDmCtrl = DmiAddrW'(32'h10);
  localparam logic [DmiAddrW-1:0] AddrSbcs   = DmiAddrW'(32'h38);
  localparam logic [DmiAddrW-1:0] AddrSbAddr = DmiAddrW'(32'h39);
  localparam logic [DmiAddrW-1:0] AddrSbData = DmiAddrW'(32'h3C);
  localparam logic [1:0]          OpRead     = 2'd1;
  localparam logic [1:0]          OpWrite    = 2'd2;
  localparam int unsigned         PollW      = $clog2(MaxPolls) + 1;

  logic [3:0]       state_q, state_d, ret_q, ret_d;
  logic             wait_q, wait_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d, exp_addr_q, exp_addr_d;
  logic             last_q, last_d, addr_valid_q, addr_valid_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             resp_fire, sb_busy;
  logic [2:0]       sb_error;
  logic             unused_resp_bits;
`ifdef DMI_SBA_PRELOADER_STATS_EN
  logic [CntW-1:0]  words_q, words_d, polls_q, polls_d;
`endif

  assign resp_fire = bus.dmi_resp_valid_i && bus.dmi_resp_ready_o;
  assign sb_busy   = bus.dmi_resp_data_i[21];
  assign sb_error  = bus.dmi_resp_data_i[14:12];
  assign unused_resp_bits = ^{bus.dmi_resp_data_i[31:22], bus.dmi_resp_data_i[20:15],
                              bus.dmi_resp_data_i[11:0]};

  // Request fields are pure functions of state, so they stay stable under backpressure.
  always_comb begin
    bus.dmi_req_valid_o = 1'b0;
    bus.dmi_req_addr_o  = '0;
    bus.dmi_req_op_o    = '0;
    bus.dmi_req_data_o  = '0;
    if (!wait_q) begin
      bus.dmi_req_valid_o = 1'b1;
      case (state_q)
        S_INIT_CTRL: begin bus.dmi_req_addr_o = AddrDmCtrl; bus.dmi_req_op_o = OpWrite; bus.dmi_req_data_o = 32'h0000_0001; end
        S_INIT_SBCS: begin bus.dmi_req_addr_o = AddrSbcs;   bus.dmi_req_op_o = OpWrite; bus.dmi_req_data_o = 32'h0005_0000; end
        S_WR_ADDR:   begin bus.dmi_req_addr_o = AddrSbAddr; bus.dmi_req_op_o = OpWrite; bus.dmi_req_data_o = addr_q; end
        S_WR_DATA:   begin bus.dmi_req_addr_o = AddrSbData; bus.dmi_req_op_o = OpWrite; bus.dmi_req_data_o = data_q; end
        S_POLL:      begin bus.dmi_req_addr_o = AddrSbcs;   bus.dmi_req_op_o = OpRead; end
        S_FINI:      begin bus.dmi_req_addr_o = AddrSbcs;   bus.dmi_req_op_o = OpWrite; bus.dmi_req_data_o = 32'h0004_0000; end
        default:     bus.dmi_req_valid_o = 1'b0;
      endcase
    end
  end

  assign bus.in_ready_o       = (state_q == S_WAIT_WORD);
  assign bus.dmi_resp_ready_o = wait_q;
  assign busy_o     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERROR);
  assign err_code_o = err_code_q;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    wait_d       = wait_q;
    addr_d       = addr_q;
    data_d       = data_q;
    last_d       = last_q;
    exp_addr_d   = exp_addr_q;
    addr_valid_d = addr_valid_q;
    poll_cnt_d   = poll_cnt_q;
    err_code_d   = err_code_q;
`ifdef DMI_SBA_PRELOADER_STATS_EN
    words_d      = words_q;
    polls_d      = polls_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d      = S_INIT_CTRL;
          wait_d       = 1'b0;
          err_code_d   = '0;
          addr_valid_d = 1'b0;
`ifdef DMI_SBA_PRELOADER_STATS_EN
          words_d      = '0;
          polls_d      = '0;
`endif
        end
      end
      S_WAIT_WORD: begin
        if (bus.in_valid_i) begin
          addr_d = bus.in_addr_i;
          data_d = bus.in_data_i;
          last_d = bus.in_last_i;
          if (bus.in_addr_i[1:0] != 2'b00) begin
            state_d    = S_ERROR;
            err_code_d = 3'd4;
          end else if (!addr_valid_q || bus.in_addr_i != exp_addr_q) begin
            state_d = S_WR_ADDR;
          end else begin
            state_d = S_WR_DATA;
          end
        end
      end
      S_INIT_CTRL, S_INIT_SBCS, S_WR_ADDR, S_WR_DATA, S_POLL, S_FINI: begin
        if (!wait_q) begin
          if (bus.dmi_req_ready_i) wait_d = 1'b1;
        end else if (resp_fire) begin
          wait_d = 1'b0;
`ifdef DMI_SBA_PRELOADER_STATS_EN
          if (state_q == S_POLL && polls_q != '1) polls_d = polls_q + 1'b1;
`endif
          if (bus.dmi_resp_resp_i != 2'd0) begin
            state_d    = S_ERROR;
            err_code_d = 3'd1;
          end else begin
            case (state_q)
              S_INIT_CTRL: state_d = S_INIT_SBCS;
              S_INIT_SBCS: state_d = S_WAIT_WORD;
              S_WR_ADDR: begin
                state_d    = S_POLL;
                ret_d      = S_WR_DATA;
                poll_cnt_d = '0;
              end
              S_WR_DATA: begin
                exp_addr_d   = addr_q + 32'd4;
                addr_valid_d = 1'b1;
                state_d      = S_POLL;
                ret_d        = last_q ? S_FINI : S_WAIT_WORD;
                poll_cnt_d   = '0;
`ifdef DMI_SBA_PRELOADER_STATS_EN
                if (words_q != '1) words_d = words_q + 1'b1;
`endif
              end
              S_POLL: begin
                if (sb_error != 3'd0) begin
                  state_d    = S_ERROR;
                  err_code_d = 3'd3;
                end else if (sb_busy) begin
                  if (poll_cnt_q == PollW'(MaxPolls - 1)) begin
                    state_d    = S_ERROR;
                    err_code_d = 3'd2;
                  end else begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                  end
                end else begin
                  state_d = ret_q;
                end
              end
              default: state_d = S_DONE;
            endcase
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      wait_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      exp_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      poll_cnt_q   <= '0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      wait_q       <= wait_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      exp_addr_q   <= exp_addr_d;
      addr_valid_q <= addr_valid_d;
      poll_cnt_q   <= poll_cnt_d;
      err_code_q   <= err_code_d;
    end
  end

`ifdef DMI_SBA_PRELOADER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
      polls_q <= '0;
    end else begin
      words_q <= words_d;
      polls_q <= polls_d;
    end
  end

  assign words_o = words_q;
  assign polls_o = polls_q;
`endif

endmodule
